// File: rtl/aibcr3aux_pasred_det.sv
// rtl/aibcr3aux_pasred_det.sv - AUX pad detect conditioner: sync, polarity, debounce, change flags
// One independent filter per channel; the debounce threshold is shared.
module aibcr3aux_pasred_det #(
  parameter int NCH         = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 8
) (
  input  logic             osc_clk,
  input  logic             dig_rstb,
  input  logic [NCH-1:0]   pad_rx,
  input  logic [NCH-1:0]   cfg_inv,
  input  logic [NCH-1:0]   cfg_bypass,
  input  logic [DEB_W-1:0] cfg_deb_cnt,
  input  logic [NCH-1:0]   chg_clr,
  output logic [NCH-1:0]   det_out,
  output logic             det_all,
  output logic [NCH-1:0]   chg_flag
);

  logic [SYNC_STAGES-1:0][NCH-1:0] sync_q;
  logic [NCH-1:0][DEB_W-1:0]       cnt;
  logic [NCH-1:0][DEB_W-1:0]       cnt_nxt;
  logic [NCH-1:0]                  s;
  logic [NCH-1:0]                  det_nxt;
  logic [DEB_W-1:0]                thr_m1;

  assign s       = sync_q[SYNC_STAGES-1] ^ cfg_inv;
  assign det_all = &det_out;

  // A zero threshold behaves like one: toggle on the first differing cycle.
  assign thr_m1 = (cfg_deb_cnt == '0) ? '0 : cfg_deb_cnt - DEB_W'(1);

  always_comb begin
    det_nxt = det_out;
    cnt_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_bypass[i]) begin
        det_nxt[i] = s[i];
      end else if (s[i] != det_out[i]) begin
        // >= rather than == so a lowered threshold fires at once instead of wrapping.
        if (cnt[i] >= thr_m1) begin
          det_nxt[i] = s[i];
        end else begin
          cnt_nxt[i] = cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge osc_clk or negedge dig_rstb) begin
    if (!dig_rstb) begin
      sync_q   <= '0;
      cnt      <= '0;
      det_out  <= '0;
      chg_flag <= '0;
    end else begin
      sync_q[0] <= pad_rx;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      cnt      <= cnt_nxt;
      det_out  <= det_nxt;
      // A change on the same edge as a clear keeps the flag set.
      chg_flag <= (det_nxt ^ det_out) | (chg_flag & ~chg_clr);
    end
  end

endmodule

// File: tb/tb_aibcr3aux_pasred_det.sv
// tb/tb_aibcr3aux_pasred_det.sv - scoreboard bench for aibcr3aux_pasred_det
// Stimulus queues expected outputs tagged with a cycle; a monitor checks them on falling edges.
module tb_aibcr3aux_pasred_det;

  logic       clk;
  logic       rst_n;
  logic [1:0] pad;
  logic [1:0] inv;
  logic [1:0] byp;
  logic [7:0] deb;
  logic [1:0] clr;
  logic [1:0] det_out;
  logic       det_all;
  logic [1:0] chg_flag;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [1:0] det;
    logic [1:0] chg;
    string      name;
  } exp_t;

  exp_t sb[$];

  aibcr3aux_pasred_det #(.NCH(2), .SYNC_STAGES(2), .DEB_W(8)) dut (
    .osc_clk     (clk),
    .dig_rstb    (rst_n),
    .pad_rx      (pad),
    .cfg_inv     (inv),
    .cfg_bypass  (byp),
    .cfg_deb_cnt (deb),
    .chg_clr     (clr),
    .det_out     (det_out),
    .det_all     (det_all),
    .chg_flag    (chg_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int c, input logic [1:0] d, input logic [1:0] g, input string n);
    exp_t e;
    e.cyc  = c;
    e.det  = d;
    e.chg  = g;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic at(input int p);
    while (cyc < p) @(negedge clk);
    #1;
  endtask

  // Monitor: every queued expectation whose cycle has arrived is compared and retired.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", sb[i].name, sb[i].cyc, cyc);
        sb.delete(i);
      end else if (sb[i].cyc == cyc) begin
        tests++;
        if (det_out !== sb[i].det || chg_flag !== sb[i].chg || det_all !== (&sb[i].det)) begin
          fails++;
          $display("FAIL %s @%0d: got det=%b all=%b chg=%b, want det=%b all=%b chg=%b",
                   sb[i].name, cyc, det_out, det_all, chg_flag,
                   sb[i].det, &sb[i].det, sb[i].chg);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #50000;
    fails++;
    $display("FAIL watchdog: time limit reached with %0d expectations pending", sb.size());
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, g, q, d, l, v, b, p, w, f, r2;
    rst_n = 1'b0;
    pad   = 2'b11;
    inv   = 2'b00;
    byp   = 2'b00;
    deb   = 8'd4;
    clr   = 2'b00;

    // Reset held, then release with both pads high.
    at(1);
    expect_at(2, 2'b00, 2'b00, "reset_a");
    expect_at(3, 2'b00, 2'b00, "reset_b");
    at(3);
    rst_n = 1'b1;
    r = cyc;
    expect_at(r + 5, 2'b00, 2'b00, "pre_qual");
    expect_at(r + 6, 2'b11, 2'b11, "qual");
    at(r + 6);
    clr = 2'b11;
    expect_at(r + 7, 2'b11, 2'b00, "clr_init");
    at(r + 7);
    clr = 2'b00;

    // 3-cycle low glitch on channel 0 is rejected.
    at(r + 8);
    g = cyc;
    pad[0] = 1'b0;
    expect_at(g + 4, 2'b11, 2'b00, "glitch_mid");
    expect_at(g + 8, 2'b11, 2'b00, "glitch_after");
    at(g + 3);
    pad[0] = 1'b1;

    // 6-cycle low pulse toggles, recovery toggles back; clear collides with the rise.
    at(g + 10);
    q = cyc;
    pad[0] = 1'b0;
    expect_at(q + 5, 2'b11, 2'b00, "pulse_hold");
    expect_at(q + 6, 2'b10, 2'b01, "pulse_fall");
    at(q + 6);
    pad[0] = 1'b1;
    expect_at(q + 11, 2'b10, 2'b01, "rise_pre");
    at(q + 11);
    clr[0] = 1'b1;
    expect_at(q + 12, 2'b11, 2'b01, "set_wins");
    expect_at(q + 13, 2'b11, 2'b00, "clr_next");
    at(q + 13);
    clr = 2'b00;

    // Threshold 0 and 1 both give a single-cycle filter.
    at(q + 14);
    d = cyc;
    deb = 8'd0;
    pad[1] = 1'b0;
    expect_at(d + 2, 2'b11, 2'b00, "thr0_pre");
    expect_at(d + 3, 2'b01, 2'b10, "thr0_fall");
    at(d + 3);
    clr = 2'b10;
    expect_at(d + 4, 2'b01, 2'b00, "thr0_clr");
    at(d + 4);
    clr = 2'b00;
    deb = 8'd1;
    pad[1] = 1'b1;
    expect_at(d + 6, 2'b01, 2'b00, "thr1_pre");
    expect_at(d + 7, 2'b11, 2'b10, "thr1_rise");

    // Lowering the threshold from 200 to 5 at cnt=50 fires on the next edge.
    at(d + 8);
    l = cyc;
    clr = 2'b11;
    deb = 8'd200;
    pad[0] = 1'b0;
    expect_at(l + 1, 2'b11, 2'b00, "lower_clr");
    expect_at(l + 52, 2'b11, 2'b00, "cnt50_hold");
    expect_at(l + 53, 2'b10, 2'b01, "lower_thr");
    at(l + 1);
    clr = 2'b00;
    at(l + 52);
    deb = 8'd5;
    at(l + 53);
    pad[0] = 1'b1;
    deb = 8'd4;
    expect_at(l + 59, 2'b11, 2'b01, "restore");
    at(l + 59);
    clr = 2'b01;
    expect_at(l + 60, 2'b11, 2'b00, "clr2");
    at(l + 60);
    clr = 2'b00;

    // Inverted channel 1 with a low pad stays detected.
    at(l + 61);
    v = cyc;
    inv[1] = 1'b1;
    pad[1] = 1'b0;
    expect_at(v + 8, 2'b11, 2'b00, "inv_steady");

    // Bypass: a 1-cycle pad pulse yields a 1-cycle det pulse 3 cycles later.
    at(v + 9);
    b = cyc;
    byp[1] = 1'b1;
    at(b + 1);
    p = cyc;
    pad[1] = 1'b1;
    expect_at(p + 2, 2'b11, 2'b00, "byp_pre");
    expect_at(p + 3, 2'b01, 2'b10, "byp_pulse");
    expect_at(p + 4, 2'b11, 2'b10, "byp_end");
    at(p + 1);
    pad[1] = 1'b0;

    at(p + 5);
    w = cyc;
    byp = 2'b00;
    inv = 2'b00;
    pad[1] = 1'b1;
    clr = 2'b11;
    expect_at(w + 8, 2'b11, 2'b00, "unbyp");
    at(w + 1);
    clr = 2'b00;

    // Asynchronous reset at cnt=3 of 4, then full requalification.
    at(w + 9);
    f = cyc;
    pad[0] = 1'b0;
    expect_at(f + 4, 2'b11, 2'b00, "rst_pre");
    expect_at(f + 5, 2'b00, 2'b00, "async_rst");
    expect_at(f + 6, 2'b00, 2'b00, "rst_hold");
    at(f + 4);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    at(f + 6);
    rst_n = 1'b1;
    r2 = cyc;
    expect_at(r2 + 5, 2'b00, 2'b00, "requal_pre");
    expect_at(r2 + 6, 2'b10, 2'b10, "requal");

    at(r2 + 10);
    while (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL %s: expectation for cycle %0d never checked", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
